// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Registered program counter with next-PC selection (sequential,
//            B/BL, CBZ/CBNZ, BR, RET), stall hold, sticky misalignment fault
//            and an optional return-address stack.
// Config   : define RAS_EN to build the return-address stack; without it RET
//            behaves as BR and ras_empty/ras_full are tied to 1/0.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned WIDTH              = 64,
  parameter logic [WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned IMM_SHIFT          = 2,
  parameter int unsigned RAS_DEPTH          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             branch_on_nonzero,
  input  logic             alu_zero,
  input  logic             uncondbranch,
  input  logic             link,
  input  logic             reg_branch,
  input  logic             ret,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [WIDTH-1:0] sign_ext_imm,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] link_addr,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             fault
);

  // One instruction step, and the mask of PC bits that must stay zero.
  localparam logic [WIDTH-1:0] C_INC      = WIDTH'(1) << IMM_SHIFT;
  localparam logic [WIDTH-1:0] C_LOW_MASK = C_INC - WIDTH'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] seq_w;
  logic [WIDTH-1:0] br_tgt_w;
  logic             taken_w;
  logic [WIDTH-1:0] sel_w;
  logic             misalign_w;
  logic             commit_w;

  // RAS view used by the next-PC mux; constant when the stack is not built.
  logic             ras_hit_w;
  logic [WIDTH-1:0] ras_top_w;

  assign seq_w     = pc_q + C_INC;
  assign br_tgt_w  = pc_q + (sign_ext_imm << IMM_SHIFT);
  assign taken_w   = uncondbranch | (branch & (alu_zero ^ branch_on_nonzero));
  assign link_addr = seq_w;

  // Target selection before the stall/fault hold; RET outranks everything.
  always_comb begin
    sel_w = seq_w;
    if (ret) begin
      sel_w = ras_hit_w ? ras_top_w : reg_target;
    end else if (reg_branch) begin
      sel_w = reg_target;
    end else if (taken_w) begin
      sel_w = br_tgt_w;
    end
  end

  assign misalign_w = (sel_w & C_LOW_MASK) != '0;
  // A misaligned target raises the fault instead of committing anything.
  assign commit_w   = !stall && !fault_q && !misalign_w;
  assign next_pc    = (fault_q || stall) ? pc_q : sel_w;
  assign pc_d       = commit_w ? sel_w : pc_q;
  assign fault_d    = fault_q | (!stall & misalign_w);

  // Architectural PC and sticky fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc    = pc_q;
  assign fault = fault_q;

`ifdef RAS_EN
  localparam int unsigned C_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned C_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(RAS_DEPTH);

  // ptr_q addresses the most recent entry; it wraps naturally (depth is 2^n).
  logic [WIDTH-1:0]   ras_q [RAS_DEPTH];
  logic [C_PTR_W-1:0] ptr_q, ptr_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               wr_en_w;
  logic [C_PTR_W-1:0] wr_idx_w;
  logic               push_w;
  logic               pop_w;

  assign ras_hit_w = cnt_q != '0;
  assign ras_top_w = ras_q[ptr_q];
  assign push_w    = link & uncondbranch & commit_w;
  assign pop_w     = ret & commit_w & ras_hit_w;

  // Stack pointer/count update; push+pop replaces the top in place.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en_w  = 1'b0;
    wr_idx_w = ptr_q;
    if (push_w && pop_w) begin
      wr_en_w = 1'b1;
    end else if (push_w) begin
      ptr_d    = ptr_q + C_PTR_W'(1);
      wr_idx_w = ptr_q + C_PTR_W'(1);
      wr_en_w  = 1'b1;
      cnt_d    = (cnt_q == C_FULL_CNT) ? cnt_q : cnt_q + C_CNT_W'(1);
    end else if (pop_w) begin
      ptr_d = ptr_q - C_PTR_W'(1);
      cnt_d = cnt_q - C_CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents after reset are irrelevant because cnt_q gates use.
  always_ff @(posedge clk) begin
    if (wr_en_w) begin
      ras_q[wr_idx_w] <= link_addr;
    end
  end

  assign ras_empty = cnt_q == '0;
  assign ras_full  = cnt_q == C_FULL_CNT;
`else
  // Without the stack, link only matters to whoever consumes link_addr.
  logic unused_link;
  assign unused_link = link;
  assign ras_hit_w   = 1'b0;
  assign ras_top_w   = '0;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer (RESET_PC=0x1000,
//            WIDTH=32, IMM_SHIFT=2, RAS_DEPTH=4). Expectations follow the
//            RAS_EN setting of the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
  localparam int unsigned W = 32;

`ifdef RAS_EN
  localparam logic C_RAS_BUILT = 1'b1;
`else
  localparam logic C_RAS_BUILT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         stall, branch, branch_on_nonzero, alu_zero;
  logic         uncondbranch, link, reg_branch, ret;
  logic [W-1:0] reg_target, sign_ext_imm;
  logic [W-1:0] pc, next_pc, link_addr;
  logic         ras_empty, ras_full, fault;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(
    .WIDTH(W), .RESET_PC(32'h1000), .IMM_SHIFT(2), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_on_nonzero(branch_on_nonzero), .alu_zero(alu_zero),
    .uncondbranch(uncondbranch), .link(link), .reg_branch(reg_branch),
    .ret(ret), .reg_target(reg_target), .sign_ext_imm(sign_ext_imm),
    .pc(pc), .next_pc(next_pc), .link_addr(link_addr),
    .ras_empty(ras_empty), .ras_full(ras_full), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; branch = 0; branch_on_nonzero = 0; alu_zero = 0;
    uncondbranch = 0; link = 0; reg_branch = 0; ret = 0;
    reg_target = '0; sign_ext_imm = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [W-1:0] a);
    idle(); reg_branch = 1; reg_target = a;
    step();
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    #1;
    check("rst_pc", pc, 32'h1000);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);
    reset = 0;
    check("seq_next", next_pc, 32'h1004);
    check("seq_link", link_addr, 32'h1004);
    step(); check("seq1", pc, 32'h1004);
    step(); check("seq2", pc, 32'h1008);
    step(); check("seq3", pc, 32'h100C);

    // Asynchronous reset between edges.
    #3 reset = 1;
    #1 check("async_rst_pc", pc, 32'h1000);
    #1 reset = 0;

    // Conditional and unconditional branches.
    jump_to(32'h2000);
    check("br_to_2000", pc, 32'h2000);
    branch = 1; alu_zero = 1; sign_ext_imm = 32'hFFFF_FFFC;
    #1 check("cbz_next", next_pc, 32'h1FF0);
    step(); check("cbz_taken", pc, 32'h1FF0);
    jump_to(32'h2000);
    branch = 1; branch_on_nonzero = 1; alu_zero = 1; sign_ext_imm = 32'hFFFF_FFFC;
    step(); check("cbnz_not_taken", pc, 32'h2004);
    idle(); uncondbranch = 1; sign_ext_imm = 32'd3;
    step(); check("b_imm3", pc, 32'h2010);
    idle(); branch = 1; branch_on_nonzero = 1; alu_zero = 0; sign_ext_imm = 32'd4;
    step(); check("cbnz_taken", pc, 32'h2020);
    idle(); branch = 1; alu_zero = 0; sign_ext_imm = 32'd8;
    step(); check("cbz_not_taken", pc, 32'h2024);

    // BL followed by RET.
    jump_to(32'h3000);
    uncondbranch = 1; link = 1; sign_ext_imm = 32'h100;
    #1 check("bl_link_addr", link_addr, 32'h3004);
    step(); check("bl_pc", pc, 32'h3400);
    check("bl_empty", ras_empty, !C_RAS_BUILT);
    idle(); ret = 1; reg_target = 32'h5000;
    step();
    check("ret_pc", pc, C_RAS_BUILT ? 32'h3004 : 32'h5000);
    check("ret_empty", ras_empty, 1);
    check("ret_full", ras_full, 0);

`ifdef RAS_EN
    // Five nested calls on a four-deep stack; the oldest is overwritten.
    jump_to(32'h3004);
    for (int i = 0; i < 5; i++) begin
      uncondbranch = 1; link = 1; sign_ext_imm = 32'h40;
      step();
    end
    idle();
    check("nest_pc", pc, 32'h3504);
    check("nest_full", ras_full, 1);
    ret = 1; reg_target = 32'h6000;
    step(); check("ret1", pc, 32'h3408);
    step(); check("ret2", pc, 32'h3308);
    step(); check("ret3", pc, 32'h3208);
    step(); check("ret4", pc, 32'h3108);
    check("ret4_empty", ras_empty, 1);
    step(); check("ret5_reg", pc, 32'h6000);
    idle();
`endif

    // Stall holds PC and stack, then the pending BL commits.
    jump_to(32'h7000);
    stall = 1; uncondbranch = 1; link = 1; sign_ext_imm = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h7000);
      check("stall_empty", ras_empty, 1);
    end
    check("stall_next", next_pc, 32'h7000);
    stall = 0;
    step(); check("unstall_pc", pc, 32'h7040);
    check("unstall_empty", ras_empty, !C_RAS_BUILT);

    // A misaligned target under stall must not fault.
    idle(); stall = 1; reg_branch = 1; reg_target = 32'h4002;
    step(); check("stall_no_fault", fault, 0);

    // Misaligned BR faults and freezes everything until reset.
    stall = 0;
    step();
    check("fault_set", fault, 1);
    check("fault_pc_hold", pc, 32'h7040);
    idle(); uncondbranch = 1; sign_ext_imm = 32'h8;
    step();
    check("fault_sticky", fault, 1);
    check("fault_pc_frozen", pc, 32'h7040);
    check("fault_next", next_pc, 32'h7040);
    idle(); ret = 1; reg_target = 32'h9000;
    step();
    check("fault_ras_frozen", ras_empty, !C_RAS_BUILT);
    check("fault_pc_ret", pc, 32'h7040);

    // Asynchronous reset clears the fault immediately.
    idle();
    #2 reset = 1;
    #1;
    check("fault_rst_fault", fault, 0);
    check("fault_rst_pc", pc, 32'h1000);
    check("fault_rst_empty", ras_empty, 1);
    #1 reset = 0;
    step(); check("post_rst_seq", pc, 32'h1004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
